// File: rtl/xlr8_lfsr_multi.sv
// rtl/xlr8_lfsr_multi.sv - multi-channel Galois LFSR block on the XLR8 data-memory register bus
// Byte-serial SEED/TAPS/DATA access through a shared pointer, coherent DATA snapshot, zero lock-up guard.
module xlr8_lfsr_multi #(
  parameter int unsigned CTRL_ADDR  = 0,
  parameter int unsigned ENA_ADDR   = 0,
  parameter int unsigned CHSEL_ADDR = 0,
  parameter int unsigned SEED_ADDR  = 0,
  parameter int unsigned TAPS_ADDR  = 0,
  parameter int unsigned DATA_ADDR  = 0,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned WIDTH      = 16,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(16'hB400)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [7:0]        dbus_in,
  output logic [7:0]        dbus_out,
  output logic              io_out_en,
  input  logic [7:0]        ramadr,
  input  logic              ramre,
  input  logic              ramwe,
  input  logic              dm_sel,
  output logic [NUM_CH-1:0] lfsr_bit
);

  localparam int unsigned NBYTES   = WIDTH / 8;
  localparam logic [1:0]  LAST_PTR = 2'(NBYTES - 1);

  logic              run_q, run_d, sor_q, sor_d, zero_q, zero_d;
  logic [NUM_CH-1:0] ena_q, ena_d, req_q, req_d, new_req;
  logic [2:0]        ch_q, ch_d;
  logic [1:0]        ptr_q, ptr_d, ptr_nxt;
  logic [WIDTH-1:0]  stage_q, stage_d, stage_wr, snap_q, snap_d;
  logic [WIDTH-1:0]  seed_q [NUM_CH];
  logic [WIDTH-1:0]  seed_d [NUM_CH];
  logic [WIDTH-1:0]  taps_q [NUM_CH];
  logic [WIDTH-1:0]  taps_d [NUM_CH];
  logic [WIDTH-1:0]  state_q [NUM_CH];
  logic [WIDTH-1:0]  state_d [NUM_CH];
  logic [WIDTH-1:0]  cur_seed, cur_taps, cur_state, stepped, nv;
  logic              wr_state, do_step, zero_set, ch_ok, ptr_last;
  logic              commit_seed, commit_taps;

  logic sel_ctrl, sel_ena, sel_chsel, sel_seed, sel_taps, sel_data;
  logic rd_ctrl, rd_ena, rd_chsel, rd_seed, rd_taps, rd_data;
  logic wr_ctrl, wr_ena, wr_chsel, wr_seed, wr_taps;

  assign sel_ctrl  = dm_sel && (ramadr == 8'(CTRL_ADDR));
  assign sel_ena   = dm_sel && (ramadr == 8'(ENA_ADDR));
  assign sel_chsel = dm_sel && (ramadr == 8'(CHSEL_ADDR));
  assign sel_seed  = dm_sel && (ramadr == 8'(SEED_ADDR));
  assign sel_taps  = dm_sel && (ramadr == 8'(TAPS_ADDR));
  assign sel_data  = dm_sel && (ramadr == 8'(DATA_ADDR));

  assign rd_ctrl  = sel_ctrl  && ramre;
  assign rd_ena   = sel_ena   && ramre;
  assign rd_chsel = sel_chsel && ramre;
  assign rd_seed  = sel_seed  && ramre;
  assign rd_taps  = sel_taps  && ramre;
  assign rd_data  = sel_data  && ramre;

  assign wr_ctrl  = sel_ctrl  && ramwe && clken;
  assign wr_ena   = sel_ena   && ramwe && clken;
  assign wr_chsel = sel_chsel && ramwe && clken;
  assign wr_seed  = sel_seed  && ramwe && clken;
  assign wr_taps  = sel_taps  && ramwe && clken;

  assign io_out_en = rd_ctrl | rd_ena | rd_chsel | rd_seed | rd_taps | rd_data;

  assign ch_ok    = ({1'b0, ch_q} < 4'(NUM_CH));
  assign ptr_last = (ptr_q == LAST_PTR);
  assign ptr_nxt  = ptr_last ? 2'd0 : ptr_q + 2'd1;

  function automatic logic [7:0] byte_of(input logic [WIDTH-1:0] v, input logic [1:0] p);
    logic [31:0] w;
    w = 32'(v);
    return w[{p, 3'b000} +: 8];
  endfunction

  always_comb begin
    cur_seed  = '0;
    cur_taps  = '0;
    cur_state = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == 3'(i)) begin
        cur_seed  = seed_q[i];
        cur_taps  = taps_q[i];
        cur_state = state_q[i];
      end
    end
  end

  always_comb begin
    dbus_out = 8'h00;
    if (rd_ctrl)                 dbus_out = {zero_q, 5'b00000, sor_q, run_q};
    else if (rd_ena)             dbus_out = 8'(ena_q);
    else if (rd_chsel)           dbus_out = {2'b00, ptr_q, 1'b0, ch_q};
    else if (rd_seed && ch_ok)   dbus_out = byte_of(cur_seed, ptr_q);
    else if (rd_taps && ch_ok)   dbus_out = byte_of(cur_taps, ptr_q);
    else if (rd_data && ch_ok)   dbus_out = (ptr_q == 2'd0) ? byte_of(cur_state, 2'd0)
                                                            : byte_of(snap_q, ptr_q);
  end

  always_comb begin
    run_d    = run_q;
    sor_d    = sor_q;
    zero_d   = zero_q;
    ena_d    = ena_q;
    ch_d     = ch_q;
    ptr_d    = ptr_q;
    stage_d  = stage_q;
    snap_d   = snap_q;
    new_req  = '0;
    zero_set = 1'b0;
    stepped  = '0;
    nv       = '0;
    wr_state = 1'b0;
    do_step  = 1'b0;
    for (int n = 0; n < NUM_CH; n++) begin
      seed_d[n]  = seed_q[n];
      taps_d[n]  = taps_q[n];
      state_d[n] = state_q[n];
    end

    stage_wr = stage_q;
    for (int b = 0; b < NBYTES; b++) begin
      if (ptr_q == 2'(b)) stage_wr[b*8 +: 8] = dbus_in;
    end
    commit_seed = wr_seed && ptr_last && ch_ok;
    commit_taps = wr_taps && ptr_last && ch_ok;

    if (wr_ctrl) begin
      run_d = dbus_in[0];
      sor_d = dbus_in[1];
      if (dbus_in[7]) zero_d = 1'b0;
    end
    if (wr_ena) ena_d = dbus_in[NUM_CH-1:0];
    if (wr_chsel) begin
      ch_d  = dbus_in[2:0];
      ptr_d = 2'd0;
    end
    if (wr_seed || wr_taps) begin
      ptr_d = ptr_nxt;
      if (ch_ok) stage_d = stage_wr;
    end
    if (rd_data && clken) begin
      ptr_d = ptr_nxt;
      if (ptr_q == 2'd0) snap_d = cur_state;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ptr_last && sor_q && ch_ok && ch_q == 3'(i)) new_req[i] = 1'b1;
      end
    end
    // Pending step-on-read requests survive clken-low cycles untouched.
    req_d = clken ? new_req : req_q;

    for (int n = 0; n < NUM_CH; n++) begin
      do_step  = clken && ((run_q && ena_q[n]) || req_q[n]);
      stepped  = state_q[n][0] ? ((state_q[n] >> 1) ^ taps_q[n]) : (state_q[n] >> 1);
      wr_state = 1'b0;
      nv       = '0;
      if (commit_seed && ch_q == 3'(n)) begin
        seed_d[n] = stage_wr;
        nv        = stage_wr;
        wr_state  = 1'b1;
      end else if (do_step) begin
        nv       = stepped;
        wr_state = 1'b1;
      end
      if (commit_taps && ch_q == 3'(n)) taps_d[n] = stage_wr;
      if (wr_state) begin
        if (nv == '0) begin
          state_d[n] = WIDTH'(1);
          zero_set   = 1'b1;
        end else begin
          state_d[n] = nv;
        end
      end
    end
    if (zero_set) zero_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= 1'b0;
      sor_q   <= 1'b0;
      zero_q  <= 1'b0;
      ena_q   <= '0;
      req_q   <= '0;
      ch_q    <= 3'd0;
      ptr_q   <= 2'd0;
      stage_q <= '0;
      snap_q  <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        seed_q[n]  <= WIDTH'(1);
        taps_q[n]  <= DEFAULT_TAPS;
        state_q[n] <= WIDTH'(1);
      end
    end else begin
      run_q   <= run_d;
      sor_q   <= sor_d;
      zero_q  <= zero_d;
      ena_q   <= ena_d;
      req_q   <= req_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      stage_q <= stage_d;
      snap_q  <= snap_d;
      for (int n = 0; n < NUM_CH; n++) begin
        seed_q[n]  <= seed_d[n];
        taps_q[n]  <= taps_d[n];
        state_q[n] <= state_d[n];
      end
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_bit
    assign lfsr_bit[n] = state_q[n][0];
  end

endmodule

// File: tb/tb_xlr8_lfsr_multi.sv
// tb/tb_xlr8_lfsr_multi.sv - directed bench for xlr8_lfsr_multi
module tb_xlr8_lfsr_multi;

  localparam logic [7:0] A_CTRL = 8'h40, A_ENA = 8'h41, A_CHSEL = 8'h42;
  localparam logic [7:0] A_SEED = 8'h43, A_TAPS = 8'h44, A_DATA = 8'h45;

  logic       clk = 1'b0, rst = 1'b1, clken = 1'b1;
  logic [7:0] dbus_in = 8'h00, dbus_out, ramadr = 8'h00;
  logic       io_out_en, ramre = 1'b0, ramwe = 1'b0, dm_sel = 1'b0;
  logic [3:0] lfsr_bit;
  logic       io_seen;
  int         pass_cnt = 0, total_cnt = 0;

  xlr8_lfsr_multi #(
    .CTRL_ADDR(A_CTRL), .ENA_ADDR(A_ENA), .CHSEL_ADDR(A_CHSEL),
    .SEED_ADDR(A_SEED), .TAPS_ADDR(A_TAPS), .DATA_ADDR(A_DATA),
    .NUM_CH(4), .WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .clken(clken), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .io_out_en(io_out_en), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
    .dm_sel(dm_sel), .lfsr_bit(lfsr_bit)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] galois(input logic [15:0] s, input logic [15:0] t);
    logic [15:0] r;
    r = s[0] ? ((s >> 1) ^ t) : (s >> 1);
    if (r == 16'h0000) r = 16'h0001;
    return r;
  endfunction

  // Bus tasks start and end on a falling edge so successive calls are back-to-back.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    dm_sel = 1'b1; ramadr = a; dbus_in = d; ramwe = 1'b1;
    @(negedge clk);
    ramwe = 1'b0; dm_sel = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    dm_sel = 1'b1; ramadr = a; ramre = 1'b1;
    #1 d = dbus_out; io_seen = io_out_en;
    @(negedge clk);
    ramre = 1'b0; dm_sel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    idle(2);
    total_cnt++; if (lfsr_bit !== 4'hF) $display("FAIL reset_bits got %h exp f", lfsr_bit); else pass_cnt++;
    rst = 1'b0;
    idle(1);
    total_cnt++; if (io_out_en !== 1'b0) $display("FAIL idle_io got %b exp 0", io_out_en); else pass_cnt++;
    rd(A_CTRL, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL reset_ctrl got %h exp 00", d); else pass_cnt++;
    total_cnt++; if (io_seen !== 1'b1) $display("FAIL read_io got %b exp 1", io_seen); else pass_cnt++;
    rd(A_ENA, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL reset_ena got %h exp 00", d); else pass_cnt++;
    rd(A_DATA, d);
    total_cnt++; if (d !== 8'h01) $display("FAIL reset_data_lo got %h exp 01", d); else pass_cnt++;
    rd(A_DATA, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL reset_data_hi got %h exp 00", d); else pass_cnt++;
  endtask

  task automatic test_seed_run();
    logic [7:0]  lo, hi;
    logic [15:0] exp_s;
    exp_s = galois(16'hACE1, 16'hB400);
    wr(A_CHSEL, 8'h02);
    wr(A_SEED, 8'hE1);
    wr(A_SEED, 8'hAC);
    total_cnt++; if (lfsr_bit !== 4'hF) $display("FAIL seed_bits got %h exp f", lfsr_bit); else pass_cnt++;
    wr(A_ENA, 8'h04);
    wr(A_CTRL, 8'h01);
    wr(A_CTRL, 8'h00);
    rd(A_DATA, lo);
    rd(A_DATA, hi);
    total_cnt++; if ({hi, lo} !== exp_s) $display("FAIL run_one_step got %h exp %h", {hi, lo}, exp_s); else pass_cnt++;
    total_cnt++; if (lfsr_bit !== {1'b1, exp_s[0], 2'b11}) $display("FAIL run_bits got %h exp %h", lfsr_bit, {1'b1, exp_s[0], 2'b11}); else pass_cnt++;
    for (int c = 0; c < 4; c += 3) begin
      wr(A_CHSEL, 8'(c));
      rd(A_DATA, lo);
      rd(A_DATA, hi);
      total_cnt++; if ({hi, lo} !== 16'h0001) $display("FAIL idle_ch%0d got %h exp 0001", c, {hi, lo}); else pass_cnt++;
    end
  endtask

  task automatic test_step_on_read();
    logic [7:0]  lo, hi;
    logic [15:0] s;
    s = 16'h0001;
    wr(A_CTRL, 8'h02);
    wr(A_CHSEL, 8'h00);
    for (int k = 0; k < 10; k++) begin
      rd(A_DATA, lo);
      total_cnt++; if (lfsr_bit[0] !== s[0]) $display("FAIL sor_midpair%0d got %b exp %b", k, lfsr_bit[0], s[0]); else pass_cnt++;
      rd(A_DATA, hi);
      total_cnt++; if ({hi, lo} !== s) $display("FAIL sor_seq%0d got %h exp %h", k, {hi, lo}, s); else pass_cnt++;
      idle(1);
      s = galois(s, 16'hB400);
    end
    wr(A_CTRL, 8'h00);
  endtask

  task automatic test_zero_guard();
    logic [7:0] d, hi;
    wr(A_CHSEL, 8'h01);
    wr(A_SEED, 8'h00);
    wr(A_SEED, 8'h00);
    total_cnt++; if (lfsr_bit[1] !== 1'b1) $display("FAIL zero_bit got %b exp 1", lfsr_bit[1]); else pass_cnt++;
    rd(A_DATA, d);
    rd(A_DATA, hi);
    total_cnt++; if ({hi, d} !== 16'h0001) $display("FAIL zero_state got %h exp 0001", {hi, d}); else pass_cnt++;
    rd(A_CTRL, d);
    total_cnt++; if (d !== 8'h80) $display("FAIL zero_flag got %h exp 80", d); else pass_cnt++;
    wr(A_CTRL, 8'h80);
    rd(A_CTRL, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL zero_clear got %h exp 00", d); else pass_cnt++;
  endtask

  task automatic test_chsel_ptr();
    logic [7:0]  d, lo, hi;
    logic [15:0] s;
    wr(A_CHSEL, 8'h03);
    wr(A_SEED, 8'h55);
    rd(A_CHSEL, d);
    total_cnt++; if (d !== 8'h13) $display("FAIL ptr_after_byte got %h exp 13", d); else pass_cnt++;
    wr(A_CHSEL, 8'h03);
    rd(A_CHSEL, d);
    total_cnt++; if (d !== 8'h03) $display("FAIL ptr_cleared got %h exp 03", d); else pass_cnt++;
    wr(A_SEED, 8'h34);
    wr(A_SEED, 8'h12);
    rd(A_SEED, d);
    total_cnt++; if (d !== 8'h34) $display("FAIL seed_readback got %h exp 34", d); else pass_cnt++;
    rd(A_DATA, lo);
    rd(A_DATA, hi);
    total_cnt++; if ({hi, lo} !== 16'h1234) $display("FAIL partial_commit got %h exp 1234", {hi, lo}); else pass_cnt++;
    wr(A_TAPS, 8'h01);
    wr(A_TAPS, 8'h80);
    rd(A_TAPS, d);
    total_cnt++; if (d !== 8'h01) $display("FAIL taps_readback got %h exp 01", d); else pass_cnt++;
    s = 16'h1234;
    for (int k = 0; k < 3; k++) s = galois(s, 16'h8001);
    wr(A_ENA, 8'h08);
    wr(A_CTRL, 8'h01);
    idle(2);
    wr(A_CTRL, 8'h00);
    rd(A_DATA, lo);
    rd(A_DATA, hi);
    total_cnt++; if ({hi, lo} !== s) $display("FAIL taps_steps got %h exp %h", {hi, lo}, s); else pass_cnt++;
    wr(A_CHSEL, 8'h05);
    rd(A_DATA, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL bad_ch_data got %h exp 00", d); else pass_cnt++;
    rd(A_CHSEL, d);
    total_cnt++; if (d !== 8'h15) $display("FAIL bad_ch_ptr got %h exp 15", d); else pass_cnt++;
    wr(A_CHSEL, 8'h03);
  endtask

  task automatic test_clken_rst();
    logic [7:0]  d, lo, hi;
    logic [15:0] s;
    s = galois(galois(galois(16'h1234, 16'h8001), 16'h8001), 16'h8001);
    clken = 1'b0;
    wr(A_SEED, 8'h00);
    rd(A_DATA, d);
    total_cnt++; if (d !== s[7:0]) $display("FAIL clken_read got %h exp %h", d, s[7:0]); else pass_cnt++;
    wr(A_CTRL, 8'h01);
    idle(3);
    clken = 1'b1;
    rd(A_CHSEL, d);
    total_cnt++; if (d !== 8'h03) $display("FAIL clken_ptr got %h exp 03", d); else pass_cnt++;
    rd(A_CTRL, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL clken_ctrl got %h exp 00", d); else pass_cnt++;
    rd(A_DATA, lo);
    rd(A_DATA, hi);
    total_cnt++; if ({hi, lo} !== s) $display("FAIL clken_state got %h exp %h", {hi, lo}, s); else pass_cnt++;
    wr(A_CTRL, 8'h03);
    wr(A_SEED, 8'hAA);
    rst = 1'b1;
    idle(2);
    total_cnt++; if (lfsr_bit !== 4'hF) $display("FAIL rst_bits got %h exp f", lfsr_bit); else pass_cnt++;
    rst = 1'b0;
    idle(1);
    rd(A_CHSEL, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL rst_chsel got %h exp 00", d); else pass_cnt++;
    rd(A_CTRL, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL rst_ctrl got %h exp 00", d); else pass_cnt++;
    rd(A_ENA, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL rst_ena got %h exp 00", d); else pass_cnt++;
    wr(A_CHSEL, 8'h03);
    rd(A_DATA, lo);
    rd(A_DATA, hi);
    total_cnt++; if ({hi, lo} !== 16'h0001) $display("FAIL rst_state got %h exp 0001", {hi, lo}); else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_seed_run();
    test_step_on_read();
    test_zero_guard();
    test_chsel_ptr();
    test_clken_rst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
